// File: rtl/vga_pkg.sv
// Shared VGA definitions for the line-fetch slice: 800x600@60 timing,
// system state codes and the fetch FSM encoding.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FRONT  = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BACK   = 88;
  localparam int H_TOTAL  = 1056;

  localparam int V_ACTIVE = 600;
  localparam int V_FRONT  = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BACK   = 23;
  localparam int V_TOTAL  = 628;

  localparam logic [7:0] ST_IDLE = 8'h01;
  localparam logic [7:0] ST_XFER = 8'h02;
  localparam logic [7:0] ST_DISP = 8'h03;

  typedef enum logic {
    FS_IDLE  = 1'b0,
    FS_FETCH = 1'b1
  } fetch_state_t;

  // Display coordinates wrap in blanking, so window offsets are 12-bit modular.
  function automatic logic [11:0] wrap_diff(input logic [11:0] a, input logic [11:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/vga_line_fetch_if.sv
// Pixel-memory read bus: request/grant address phase, in-order rvalid data phase.
interface vga_line_fetch_if #(
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [PIX_W-1:0]  mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/line_buffer_dp.sv
// Two-bank line buffer: one write port, one registered read port.
// Bank contents are not reset.
module line_buffer_dp
  import vga_pkg::*;
#(
  parameter int DEPTH = 200,
  parameter int DW    = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [IW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic          rbank,
  input  logic [IW-1:0] ridx,
  output logic [DW-1:0] rdata
);

  localparam int AW = $clog2(2 * DEPTH);

  logic [DW-1:0] mem [2*DEPTH];
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;

  // Flatten bank + index into one storage address.
  always_comb begin
    waddr = wbank ? AW'(DEPTH) + AW'(widx) : AW'(widx);
    raddr = rbank ? AW'(DEPTH) + AW'(ridx) : AW'(ridx);
  end

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Line fetcher: prefetches one source row into the back line bank while the
// front bank is scanned out with integer upscaling.
// Optional macro VGA_BORDER_EN: 1-pixel white frame around the image window.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int W        = 200,
  parameter int H        = 150,
  parameter int STARTROW = 0,
  parameter int STARTCOL = 0,
  parameter int SCALE    = 4,
  parameter int PIX_W    = 16,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        state,
  input  logic              spram_rd_sig,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  vga_line_fetch_if.master  mem,
  output logic [PIX_W-1:0]  pix_rgb,
  output logic              pix_de,
  output logic              fetch_busy,
  output logic              overrun
);

  localparam int SH  = $clog2(SCALE);
  localparam int IW  = $clog2(W);
  localparam int CW  = $clog2(W + 1);
  localparam int DCW = CW + 1;

  localparam logic [11:0]       WS      = 12'(W * SCALE);
  localparam logic [11:0]       HS      = 12'(H * SCALE);
  localparam logic [11:0]       SC_MASK = 12'(SCALE - 1);
  localparam logic [11:0]       ROW0    = 12'(STARTROW);
  localparam logic [11:0]       COL0    = 12'(STARTCOL);
  localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(W);
  localparam logic [CW-1:0]     W_LAST  = CW'(W - 1);
`ifdef VGA_BORDER_EN
  localparam logic [11:0]       WS2     = 12'(W * SCALE + 2);
  localparam logic [11:0]       HS2     = 12'(H * SCALE + 2);
`endif

  fetch_state_t      fsm;
  logic              front;
  logic [CW-1:0]     req_cnt;
  logic [CW-1:0]     wr_idx;
  logic [DCW-1:0]    drop_cnt;

  logic              disp;
  logic              busy;
  logic [11:0]       d_trig;
  logic [11:0]       d_swap;
  logic              trig;
  logic              swap;
  logic [ADDR_W-1:0] base;
  logic              gnt_fire;
  logic              rv_drop;
  logic              rv_take;
  logic [DCW-1:0]    outstanding;
  logic [DCW-1:0]    abort_drop;
  logic [IW-1:0]     wr_widx;

  logic [11:0]       xr;
  logic [11:0]       yr;
  logic              in_win;
  logic [IW-1:0]     rd_col;
  logic [PIX_W-1:0]  rd_data;
  logic              win_q;
`ifdef VGA_BORDER_EN
  logic              border;
  logic              brd_q;
`endif

  // Line-end decode and read-bus bookkeeping.
  always_comb begin
    disp     = (state == ST_DISP);
    busy     = (fsm == FS_FETCH);
    d_trig   = wrap_diff(ypos + 12'd2, ROW0);
    d_swap   = wrap_diff(ypos + 12'd1, ROW0);
    trig     = spram_rd_sig && disp && (d_trig < HS) && ((d_trig & SC_MASK) == '0);
    swap     = spram_rd_sig && disp && (d_swap < HS) && ((d_swap & SC_MASK) == '0);
    base     = ADDR_W'(d_trig >> SH) * W_A;
    gnt_fire = mem.mem_req && mem.mem_gnt;
    rv_drop  = mem.mem_rvalid && (drop_cnt != '0);
    rv_take  = mem.mem_rvalid && (drop_cnt == '0) && busy && disp;
    wr_widx  = IW'(wr_idx);
    // Reads granted but not yet returned, including this cycle's activity;
    // after an abort these are skipped so a restarted fetch stays aligned.
    outstanding = DCW'(req_cnt) + DCW'(gnt_fire) - DCW'(wr_idx) - DCW'(rv_take);
    abort_drop  = drop_cnt - DCW'(rv_drop) + outstanding;
  end

  // Fetch FSM, request issue, bank swap and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= FS_IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      req_cnt      <= '0;
      wr_idx       <= '0;
      drop_cnt     <= '0;
      front        <= 1'b0;
      overrun      <= 1'b0;
      fetch_busy   <= 1'b0;
    end else if (!disp) begin
      fsm         <= FS_IDLE;
      mem.mem_req <= 1'b0;
      fetch_busy  <= 1'b0;
      overrun     <= 1'b0;
      req_cnt     <= '0;
      wr_idx      <= '0;
      drop_cnt    <= abort_drop;
    end else begin
      if (gnt_fire) begin
        mem.mem_addr <= mem.mem_addr + 1'b1;
        req_cnt      <= req_cnt + 1'b1;
        if (req_cnt == W_LAST) mem.mem_req <= 1'b0;
      end
      if (rv_drop) drop_cnt <= drop_cnt - 1'b1;
      if (rv_take) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == W_LAST) begin
          fsm        <= FS_IDLE;
          fetch_busy <= 1'b0;
        end
      end
      if (swap) front <= ~front;
      if (busy && (swap || trig)) overrun <= 1'b1;
      // Later assignments override the progress updates above: an abort
      // discards the current fetch, and a start (possibly in the same cycle
      // as the abort) reloads all counters.
      if (busy && swap) begin
        fsm         <= FS_IDLE;
        fetch_busy  <= 1'b0;
        mem.mem_req <= 1'b0;
        req_cnt     <= '0;
        wr_idx      <= '0;
        drop_cnt    <= abort_drop;
      end
      if (trig && (!busy || swap)) begin
        fsm          <= FS_FETCH;
        fetch_busy   <= 1'b1;
        mem.mem_req  <= 1'b1;
        mem.mem_addr <= base;
        req_cnt      <= '0;
        wr_idx       <= '0;
      end
    end
  end

  // Window decode and scaled column for the front-bank read.
  always_comb begin
    xr     = wrap_diff(xpos, COL0);
    yr     = wrap_diff(ypos, ROW0);
    in_win = (xr < WS) && (yr < HS);
    rd_col = IW'(xr >> SH);
`ifdef VGA_BORDER_EN
    border = ((xr + 12'd1) < WS2) && ((yr + 12'd1) < HS2) && !in_win;
`endif
  end

  line_buffer_dp #(
    .DEPTH (W),
    .DW    (PIX_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (rv_take),
    .wbank (~front),
    .widx  (wr_widx),
    .wdata (mem.mem_rdata),
    .rbank (front),
    .ridx  (rd_col),
    .rdata (rd_data)
  );

  // First display stage, aligned with the registered bank read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= 1'b0;
`ifdef VGA_BORDER_EN
      brd_q <= 1'b0;
`endif
    end else begin
      win_q <= disp && in_win;
`ifdef VGA_BORDER_EN
      brd_q <= disp && border;
`endif
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_rgb <= '0;
      pix_de  <= 1'b0;
    end else begin
      pix_de <= disp && win_q;
      if (!disp)       pix_rgb <= '0;
      else if (win_q)  pix_rgb <= rd_data;
`ifdef VGA_BORDER_EN
      else if (brd_q)  pix_rgb <= '1;
`endif
      else             pix_rgb <= '0;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch; memory word at address a reads as a ^ 16'h5A5A.
`timescale 1ns/1ps
module tb_vga_line_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  state;
  logic        spram_rd_sig;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [15:0] pix_rgb;
  logic        pix_de;
  logic        fetch_busy;
  logic        overrun;
  logic        gnt_en;

  int          n_vec = 0;
  int          n_err = 0;
  int          grant_cnt = 0;
  logic [15:0] first_addr = '0;
  logic [15:0] last_addr = '0;
  logic [15:0] rq[$];
  logic [15:0] rtmp;

`ifdef VGA_BORDER_EN
  localparam logic [15:0] EDGE_EXP = 16'hFFFF;
`else
  localparam logic [15:0] EDGE_EXP = 16'h0000;
`endif

  vga_line_fetch_if #(.PIX_W(16), .ADDR_W(16)) bus();

  vga_line_fetch #(
    .W(200), .H(150), .STARTROW(0), .STARTCOL(0), .SCALE(4), .PIX_W(16), .ADDR_W(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .state        (state),
    .spram_rd_sig (spram_rd_sig),
    .xpos         (xpos),
    .ypos         (ypos),
    .mem          (bus.master),
    .pix_rgb      (pix_rgb),
    .pix_de       (pix_de),
    .fetch_busy   (fetch_busy),
    .overrun      (overrun)
  );

  always #12 clk = ~clk;

  assign bus.mem_gnt = gnt_en;

  // Memory model: log each granted address, return data in order.
  always @(posedge clk) begin
    if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1) begin
      rq.push_back(bus.mem_addr);
      if (grant_cnt == 0) first_addr = bus.mem_addr;
      last_addr = bus.mem_addr;
      grant_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rq.size() != 0) begin
      rtmp = rq.pop_front();
      bus.mem_rdata  = rtmp ^ 16'h5A5A;
      bus.mem_rvalid = 1'b1;
    end else begin
      bus.mem_rdata  = '0;
      bus.mem_rvalid = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [11:0] y);
    ypos = y;
    spram_rd_sig = 1'b1;
    tick();
    spram_rd_sig = 1'b0;
  endtask

  task automatic show(input logic [11:0] x, input logic [11:0] y);
    xpos = x;
    ypos = y;
    tick();
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (fetch_busy === 1'b1 && i < 1000) begin
      tick();
      i++;
    end
    chk(tag, 32'(fetch_busy), 32'd0);
  endtask

  initial begin
    state = 8'h03;
    spram_rd_sig = 1'b0;
    xpos = '0;
    ypos = '0;
    gnt_en = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("rst_pix_de", 32'(pix_de), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Row 0: trigger at ypos 4094 (d=0), swap at ypos 4095 (s=0)
    grant_cnt = 0;
    pulse(12'd4094);
    chk("r0_busy", 32'(fetch_busy), 32'd1);
    chk("r0_req", 32'(bus.mem_req), 32'd1);
    chk("r0_addr0", 32'(bus.mem_addr), 32'd0);
    wait_idle("r0_done");
    chk("r0_grants", 32'(grant_cnt), 32'd200);
    chk("r0_first", 32'(first_addr), 32'd0);
    chk("r0_last", 32'(last_addr), 32'd199);
    chk("r0_req_off", 32'(bus.mem_req), 32'd0);
    pulse(12'd4095);
    chk("r0_no_ovr", 32'(overrun), 32'd0);
    show(12'd0, 12'd0);
    chk("px_0_0", 32'(pix_rgb), 32'h5A5A);
    chk("de_0_0", 32'(pix_de), 32'd1);
    show(12'd3, 12'd0);
    chk("px_3_0", 32'(pix_rgb), 32'h5A5A);
    show(12'd4, 12'd0);
    chk("px_4_0", 32'(pix_rgb), 32'h5A5B);
    show(12'd799, 12'd3);
    chk("px_799", 32'(pix_rgb), 32'h5A9D);
    chk("de_799", 32'(pix_de), 32'd1);
    show(12'd800, 12'd0);
    chk("px_800", 32'(pix_rgb), 32'(EDGE_EXP));
    chk("de_800", 32'(pix_de), 32'd0);
    show(12'd900, 12'd300);
    chk("px_far", 32'(pix_rgb), 32'd0);

    // Row mapping: ypos 6 -> row 2, addresses 400..599
    grant_cnt = 0;
    pulse(12'd6);
    chk("r2_addr0", 32'(bus.mem_addr), 32'd400);
    wait_idle("r2_done");
    chk("r2_first", 32'(first_addr), 32'd400);
    chk("r2_last", 32'(last_addr), 32'd599);
    chk("r2_grants", 32'(grant_cnt), 32'd200);
    pulse(12'd7);
    show(12'd9, 12'd8);
    chk("px_9_8", 32'(pix_rgb), 32'h5BC8);
    chk("r2_no_ovr", 32'(overrun), 32'd0);

    // Stalled grant: fetch of row 3 cannot complete before the swap
    gnt_en = 1'b0;
    pulse(12'd10);
    repeat (900) tick();
    chk("stall_addr", 32'(bus.mem_addr), 32'd600);
    chk("stall_req", 32'(bus.mem_req), 32'd1);
    chk("stall_busy", 32'(fetch_busy), 32'd1);
    pulse(12'd11);
    chk("swap_ovr", 32'(overrun), 32'd1);
    chk("swap_busy", 32'(fetch_busy), 32'd0);
    chk("swap_req", 32'(bus.mem_req), 32'd0);
    gnt_en = 1'b1;
    repeat (10) tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    state = 8'h02;
    tick();
    chk("ovr_clr", 32'(overrun), 32'd0);
    state = 8'h03;
    tick();

    // Trigger while fetching (no swap): ignored, overrun set
    gnt_en = 1'b0;
    pulse(12'd14);
    chk("r4_addr0", 32'(bus.mem_addr), 32'd800);
    pulse(12'd18);
    chk("retrig_ovr", 32'(overrun), 32'd1);
    chk("retrig_busy", 32'(fetch_busy), 32'd1);
    chk("retrig_addr", 32'(bus.mem_addr), 32'd800);

    // Leave display state mid-fetch
    show(12'd5, 12'd5);
    chk("pre_leave_de", 32'(pix_de), 32'd1);
    state = 8'h02;
    tick();
    chk("leave_req", 32'(bus.mem_req), 32'd0);
    chk("leave_busy", 32'(fetch_busy), 32'd0);
    chk("leave_de", 32'(pix_de), 32'd0);
    chk("leave_rgb", 32'(pix_rgb), 32'd0);
    chk("leave_ovr", 32'(overrun), 32'd0);

    // Asynchronous reset around word 100 of a fetch, then recover
    gnt_en = 1'b1;
    state = 8'h03;
    tick();
    grant_cnt = 0;
    pulse(12'd4094);
    for (int i = 0; i < 500 && grant_cnt < 100; i++) @(posedge clk);
    chk("mid_reached", 32'(grant_cnt >= 100), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.mem_req), 32'd0);
    chk("arst_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_busy", 32'(fetch_busy), 32'd0);
    chk("arst_de", 32'(pix_de), 32'd0);
    chk("arst_rgb", 32'(pix_rgb), 32'd0);
    repeat (5) tick();
    rst_n = 1'b1;
    tick();
    grant_cnt = 0;
    pulse(12'd2);
    chk("r1_addr0", 32'(bus.mem_addr), 32'd200);
    wait_idle("r1_done");
    chk("r1_grants", 32'(grant_cnt), 32'd200);
    chk("r1_first", 32'(first_addr), 32'd200);
    chk("r1_last", 32'(last_addr), 32'd399);
    pulse(12'd3);
    show(12'd5, 12'd4);
    chk("px_5_4", 32'(pix_rgb), 32'h5A93);
    chk("de_5_4", 32'(pix_de), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
